reg_piso_tx: RTL and testbench
==============================

// Module: reg_piso_tx
// PURPOSE
//   Parallel-in/serial-out transmit register: the serial end of the parallel register path.
//   Captures a WIDTH-bit word with a valid/ready handshake and shifts it out one bit per clock.
//   Emits framing strobes (first/last) so a downstream serial receiver can rebuild the word.
//   Sits between a parallel register stage and a 1-bit link; supports gapless back-to-back frames.
// PARAMETERS
//   WIDTH      4   data word width in bits (>= 2)
//   MSB_FIRST  1   1: shift din[WIDTH-1] first; 0: shift din[0] first
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst_n       in   1      asynchronous, active-low reset; no other clock or reset
//   load_valid  in   1      din holds a word to transmit
//   din         in   WIDTH  parallel word, sampled only on handshake
//   load_ready  out  1      block can accept a word this cycle
//   sout        out  1      serial data bit
//   sout_valid  out  1      sout carries a frame bit this cycle
//   sout_first  out  1      first bit of frame
//   sout_last   out  1      last bit of frame (data MSB/LSB, or parity bit when enabled)
//   busy        out  1      frame in progress (== sout_valid)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE, shift reg=0, counter=0; load_ready=1, all other outputs 0.
//     Reset mid-frame aborts the frame immediately; no partial bits after rst_n rises.
//   - FSM: IDLE -> SHIFT on accept; SHIFT -> PARITY (PARITY_EN only) after the last data bit;
//     final frame cycle -> SHIFT on accept, else -> IDLE.
//   - Accept = load_valid && load_ready at a rising edge; din is captured into the shift register.
//   - load_ready = 1 in IDLE and in the final frame cycle (sout_last=1); 0 otherwise.
//   - Latency: accept at edge k -> first bit on sout in cycle k+1 with sout_first=1.
//     Data bits occupy cycles k+1..k+WIDTH; the parity bit, when enabled, occupies k+WIDTH+1.
//   - Back-to-back: an accept in the final cycle starts the next frame's first bit in the next
//     cycle. There is no idle gap and sout_valid stays 1.
//   - Bit counter: 0..WIDTH-1, width $clog2(WIDTH+1). Wraps to 0 on a new frame and never overflows.
//   - sout, sout_first and sout_last are 0 whenever sout_valid=0.
//   - din and load_valid changes while load_ready=0 are ignored.
//   - sout_first and sout_last are never both 1 (WIDTH >= 2).
// CONFIGURATION
//   PARITY_EN defined: one extra bit follows the data bits = even parity (XOR of captured word).
//     sout_last moves to the parity cycle; frame length WIDTH+1.
//   PARITY_EN undefined: no PARITY state; frame length WIDTH; sout_last on the final data bit.
// TESTING
//   1. WIDTH=4, MSB_FIRST=1, din=4'b1011 accepted at edge k -> sout 1,0,1,1 in cycles k+1..k+4.
//      first@k+1, last@k+4; load_ready=0 during k+1..k+3.
//   2. Back-to-back: 4'b1011 then 4'b0110 held valid -> 8 consecutive valid bits 1,0,1,1,0,1,1,0.
//      Second accept occurs in the last cycle of frame 1; no gap.
//   3. WIDTH=8, MSB_FIRST=0, din=8'hA5 -> sout 1,0,1,0,0,1,0,1; sout_last on 8th bit.
//   4. rst_n low during bit 2 of frame 4'b1011 -> outputs 0 and load_ready=1 asynchronously.
//      After release: no residual bits; a new word transmits cleanly.
//   5. PARITY_EN, din=4'b1011 -> bits 1,0,1,1,1 (parity=1), sout_last on the 5th bit.
//      With din=4'b0110 the parity bit is 0.
//   6. load_valid=0 for 20 cycles after reset -> sout_valid=0, sout=0, load_ready=1 throughout.

Source files
------------

// File: rtl/reg_piso_tx.sv
// Parallel-in/serial-out transmit register with valid/ready load and first/last framing strobes.
// Optional even-parity trailer bit when the PARITY_EN macro is defined.
module reg_piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] din,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             sout_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_next;
   logic [WIDTH-1:0] sreg, sreg_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             accept;
`ifdef PARITY_EN
   logic             par, par_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
`ifdef PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         sreg  <= sreg_next;
         cnt   <= cnt_next;
`ifdef PARITY_EN
         par   <= par_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      sreg_next  = sreg;
      cnt_next   = cnt;
`ifdef PARITY_EN
      par_next   = par;
`endif
      sout       = 1'b0;
      sout_last  = 1'b0;
      sout_valid = (state != IDLE);
      sout_first = (state == SHIFT) && (cnt == '0);

      case (state)
         SHIFT: begin
            sout = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
`ifndef PARITY_EN
            sout_last = (cnt == CNT_LAST);
`endif
         end
`ifdef PARITY_EN
         PARITY: begin
            sout      = par;
            sout_last = 1'b1;
         end
`endif
         default: ;
      endcase

      busy       = sout_valid;
      load_ready = (state == IDLE) || sout_last;
      accept     = load_valid && load_ready;

      // An accept in the final frame cycle overrides the normal wind-down, giving gapless frames.
      if (accept) begin
         state_next = SHIFT;
         sreg_next  = din;
         cnt_next   = '0;
`ifdef PARITY_EN
         par_next   = ^din;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt == CNT_LAST) begin
`ifdef PARITY_EN
                  state_next = PARITY;
`else
                  state_next = IDLE;
`endif
                  sreg_next = '0;
                  cnt_next  = '0;
               end else begin
                  if (MSB_FIRST)
                     sreg_next = {sreg[WIDTH-2:0], 1'b0};
                  else
                     sreg_next = {1'b0, sreg[WIDTH-1:1]};
                  cnt_next = cnt + CW'(1);
               end
            end
`ifdef PARITY_EN
            PARITY: begin
               state_next = IDLE;
               par_next   = 1'b0;
            end
`endif
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_piso_tx.sv
// Self-checking bench for reg_piso_tx: WIDTH=4 MSB-first and WIDTH=8 LSB-first instances.
// Expected values follow the PARITY_EN macro when it is defined for the build.
module tb_reg_piso_tx;

`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int NV  = 12;
`else
   localparam bit PAR = 1'b0;
   localparam int NV  = 11;
`endif

   logic       clk;
   logic       rst_n;
   logic       lv_a, lv_b;
   logic [3:0] din_a;
   logic [7:0] din_b;
   logic       ready_a, sout_a, valid_a, first_a, last_a, busy_a;
   logic       ready_b, sout_b, valid_b, first_b, last_b, busy_b;

   int n_tests = 0;
   int n_fail  = 0;

   // exp bits: {load_ready, sout_valid, busy, sout, sout_first, sout_last}
   typedef struct {
      logic       lv;
      logic [3:0] din;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[12];

   reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .din(din_a), .load_ready(ready_a),
      .sout(sout_a), .sout_valid(valid_a), .sout_first(first_a), .sout_last(last_a), .busy(busy_a)
   );

   reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .din(din_b), .load_ready(ready_b),
      .sout(sout_b), .sout_valid(valid_b), .sout_first(first_b), .sout_last(last_b), .busy(busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [5:0] obs_a();
      return {ready_a, valid_a, busy_a, sout_a, first_a, last_a};
   endfunction

   function automatic logic [5:0] obs_b();
      return {ready_b, valid_b, busy_b, sout_b, first_b, last_b};
   endfunction

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic send_a(input string tag, input logic [3:0] w);
      logic [5:0] e;
      lv_a  = 1'b1;
      din_a = w;
      @(posedge clk); #1;
      lv_a  = 1'b0;
      din_a = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         e = {(i == 3) && !PAR, 1'b1, 1'b1, w[3-i], i == 0, (i == 3) && !PAR};
         chk($sformatf("%s bit%0d", tag, i), obs_a(), e);
      end
      if (PAR) begin
         @(posedge clk); #1;
         chk($sformatf("%s parity", tag), obs_a(), {4'b1110 | {3'b000, ^w}, 2'b01});
      end
      @(posedge clk); #1;
      chk($sformatf("%s idle", tag), obs_a(), 6'b100000);
   endtask

   initial begin
      logic [7:0] wb;
      logic [5:0] e;

`ifdef PARITY_EN
      vecs[0]  = '{1'b0, 4'h0, 6'b100000};
      vecs[1]  = '{1'b1, 4'hB, 6'b011110};
      vecs[2]  = '{1'b0, 4'h0, 6'b011000};
      vecs[3]  = '{1'b0, 4'h0, 6'b011100};
      vecs[4]  = '{1'b0, 4'h0, 6'b011100};
      vecs[5]  = '{1'b0, 4'h0, 6'b111101};
      vecs[6]  = '{1'b1, 4'h6, 6'b011010};
      vecs[7]  = '{1'b1, 4'hF, 6'b011100};
      vecs[8]  = '{1'b0, 4'h0, 6'b011100};
      vecs[9]  = '{1'b0, 4'h0, 6'b011000};
      vecs[10] = '{1'b0, 4'h0, 6'b111001};
      vecs[11] = '{1'b0, 4'h0, 6'b100000};
`else
      vecs[0]  = '{1'b0, 4'h0, 6'b100000};
      vecs[1]  = '{1'b1, 4'hB, 6'b011110};
      vecs[2]  = '{1'b0, 4'h0, 6'b011000};
      vecs[3]  = '{1'b0, 4'h0, 6'b011100};
      vecs[4]  = '{1'b0, 4'h0, 6'b111101};
      vecs[5]  = '{1'b1, 4'h6, 6'b011010};
      vecs[6]  = '{1'b1, 4'hF, 6'b011100};
      vecs[7]  = '{1'b0, 4'h0, 6'b011100};
      vecs[8]  = '{1'b0, 4'h0, 6'b111001};
      vecs[9]  = '{1'b0, 4'h0, 6'b100000};
      vecs[10] = '{1'b0, 4'h0, 6'b100000};
      vecs[11] = '{1'b0, 4'h0, 6'b100000};
`endif

      rst_n = 1'b0;
      lv_a  = 1'b1;
      din_a = 4'hB;
      lv_b  = 1'b1;
      din_b = 8'hFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset a", obs_a(), 6'b100000);
      chk("reset b", obs_b(), 6'b100000);
      lv_a  = 1'b0;
      lv_b  = 1'b0;
      rst_n = 1'b1;

      // Idle for 20 cycles with load_valid low
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("idle%0d a", i), obs_a(), 6'b100000);
         if (i % 5 == 0) chk($sformatf("idle%0d b", i), obs_b(), 6'b100000);
      end

      // Single frame, back-to-back frame, ignored din while not ready
      for (int i = 0; i < NV; i++) begin
         lv_a  = vecs[i].lv;
         din_a = vecs[i].din;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", i), obs_a(), vecs[i].exp);
      end
      lv_a = 1'b0;

      // WIDTH=8, LSB first, 8'hA5
      wb    = 8'hA5;
      lv_b  = 1'b1;
      din_b = wb;
      @(posedge clk); #1;
      lv_b  = 1'b0;
      din_b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         e = {(i == 7) && !PAR, 1'b1, 1'b1, wb[i], i == 0, (i == 7) && !PAR};
         chk($sformatf("lsb8 bit%0d", i), obs_b(), e);
      end
      if (PAR) begin
         @(posedge clk); #1;
         chk("lsb8 parity", obs_b(), 6'b111001);
      end
      @(posedge clk); #1;
      chk("lsb8 idle", obs_b(), 6'b100000);

      // Asynchronous reset during bit 2 of 4'b1011
      lv_a  = 1'b1;
      din_a = 4'hB;
      @(posedge clk); #1;
      lv_a  = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-reset bit2", obs_a(), 6'b011100);
      #2 rst_n = 1'b0;
      #1 chk("async reset", obs_a(), 6'b100000);
      @(posedge clk); #1;
      chk("held reset", obs_a(), 6'b100000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-reset idle", obs_a(), 6'b100000);
      @(posedge clk); #1;
      chk("post-reset idle2", obs_a(), 6'b100000);
      send_a("after-reset 0110", 4'h6);
      send_a("frame 1011", 4'hB);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
